// File: rtl/regfile_param.sv
// Parametrised multi-port register file: registered reads, two prioritised write
// ports, optional write-first bypass, optional hardwired-zero r0 and external top register.
module regfile_param #(
    parameter int unsigned  DW      = 8,
    parameter int unsigned  DEPTH   = 8,
    parameter int unsigned  NRD     = 2,
    parameter bit           BYPASS  = 1'b1,
    parameter bit           ZERO_R0 = 1'b0,
    parameter bit           EXT_TOP = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [DW-1:0]     ext_in,
    output logic              wr_drop
);

    localparam logic [AW-1:0] TopAddr = AW'(DEPTH - 1);

    function automatic logic is_ro(input logic [AW-1:0] a);
        return (ZERO_R0 && (a == '0)) || (EXT_TOP && (a == TopAddr));
    endfunction

    logic collide;
    logic wr0_ok;
    logic wr1_ok;
    logic drop_d;

    always_comb begin
        collide = we0 && we1 && (wa0 == wa1);
        wr1_ok  = we1 && !is_ro(wa1);
        wr0_ok  = we0 && !is_ro(wa0) && !collide;
        // A collision drops port 0 even when port 1 itself targets a read-only register.
        drop_d  = (we0 && is_ro(wa0)) || (we1 && is_ro(wa1)) || collide;
    end

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr0_ok) mem_q[wa0] <= wd0;
            if (wr1_ok) mem_q[wa1] <= wd1;
        end
    end

    logic [NRD*DW-1:0] rd_d;

    always_comb begin
        rd_d = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (ZERO_R0 && (ra[i*AW +: AW] == '0)) begin
                rd_d[i*DW +: DW] = '0;
            end else if (EXT_TOP && (ra[i*AW +: AW] == TopAddr)) begin
                rd_d[i*DW +: DW] = ext_in;
            end else if (BYPASS && wr1_ok && (wa1 == ra[i*AW +: AW])) begin
                rd_d[i*DW +: DW] = wd1;
            end else if (BYPASS && wr0_ok && (wa0 == ra[i*AW +: AW])) begin
                rd_d[i*DW +: DW] = wd0;
            end else begin
                rd_d[i*DW +: DW] = mem_q[ra[i*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd      <= '0;
            wr_drop <= 1'b0;
        end else begin
            rd      <= rd_d;
            wr_drop <= drop_d;
        end
    end

endmodule
